binario_bcd: RTL and testbench
==============================

BINARIO_BCD -- requirements
Module: binario_bcd

Interface
REQ-001 SHALL have parameter DATA_W, default 8: binary input width; supported range 4..9.
REQ-002 SHALL have port iClk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port iReset, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port iStart, input, 1: conversion request; sampled only in IDLE.
REQ-005 SHALL have port ivBinario, input, DATA_W: unsigned binary value; captured on an accepted iStart.
REQ-006 SHALL have port oBusy, output, 1: high while in CONV or DONE.
REQ-007 SHALL have port oDone, output, 1: one-cycle pulse when a new result is presented.
REQ-008 SHALL have ports ovUnidades, ovDecenas, ovCentenas, output, 4 each: BCD units, tens and hundreds of the last result.
REQ-009 SHALL have port oOverflow, output, 1: high when the last result exceeded 99 and was clamped (see Configuration).

Function
REQ-010 SHALL implement the FSM IDLE -> CONV -> DONE -> IDLE.
REQ-011 IDLE with iStart=1 SHALL capture ivBinario into a shift register, clear the BCD scratch digits and the iteration counter, and go to CONV.
REQ-012 CONV SHALL run exactly DATA_W double-dabble iterations, one per cycle.
REQ-013 Each iteration SHALL first add 3 to every scratch digit >= 5, then shift {digits, shift register} left by one.
REQ-014 After the DATA_W-th iteration, the FSM SHALL go to DONE.
REQ-015 DONE SHALL load the output digit registers and oOverflow, assert oDone for that single cycle, and return to IDLE on the next edge.
REQ-016 Latency: iStart sampled at edge k SHALL put oDone high in the cycle following edge k+DATA_W+1 (DATA_W=8: oDone high 9 cycles after the start edge).
REQ-017 iStart in CONV or DONE SHALL be ignored, with no queuing; ivBinario changes after capture SHALL NOT affect the result.
REQ-018 Output digits SHALL hold their value between DONE cycles and SHALL change only in DONE.
REQ-019 Each digit output SHALL always lie in 0..9; ovCentenas SHALL be <= 5 for DATA_W=9.
REQ-020 oBusy SHALL be combinational from state; oDone and the digit outputs SHALL be registered.
REQ-021 Back-to-back conversions: iStart held high SHALL start a new conversion on the first IDLE cycle after DONE.

Reset
REQ-022 iReset=1 SHALL immediately force IDLE and clear the shift register, scratch digits, iteration counter, all digit outputs, oDone, oOverflow and oBusy to 0.
REQ-023 Reset during CONV SHALL abort the conversion with no oDone pulse.
REQ-024 After iReset deasserts, the first rising edge SHALL already accept iStart.

Configuration
REQ-025 With macro BCD_CLAMP_99_EN defined, a result > 99 SHALL produce ovCentenas=0, ovDecenas=9, ovUnidades=9 and oOverflow=1; a result <= 99 SHALL give oOverflow=0.
REQ-026 Without BCD_CLAMP_99_EN, the full three-digit result SHALL be output and oOverflow SHALL be tied to 0.

Structure
REQ-027 A shared package SHALL hold the FSM state encodings (IDLE, CONV, DONE), the BCD add-3 threshold (5) and the clamp digit constant (9).
REQ-028 The per-digit "add 3 if >= 5" correction SHALL be a sub-module named bcd_ajuste_digito, instantiated three times.

Verification
REQ-029 Bench SHALL check: ivBinario=0, iStart pulse -> oDone after 9 cycles, digits 0/0/0, oOverflow=0.
REQ-030 Bench SHALL check: ivBinario=255, no macro -> 2/5/5, oOverflow=0; with BCD_CLAMP_99_EN -> 0/9/9, oOverflow=1.
REQ-031 Bench SHALL check: ivBinario=99 -> 0/9/9, oOverflow=0 in both builds; ivBinario=100 with macro -> 0/9/9, oOverflow=1.
REQ-032 Bench SHALL check: start with 37, then iStart pulsed with 200 on cycle 3 of CONV -> single oDone, result 0/3/7.
REQ-033 Bench SHALL check: iReset asserted on cycle 4 of CONV -> outputs 0 immediately, no oDone; a new start with 58 -> 0/5/8 after 9 cycles.
REQ-034 Bench SHALL check: iStart held high for 30 cycles with 123 -> an oDone pulse every 10 cycles, digits 1/2/3 without the macro.

Source files
------------

// File: rtl/binario_bcd_pkg.sv
// -----------------------------------------------------------------------------
// binario_bcd_pkg
// Shared definitions for the binary-to-BCD converter:
//   - state_t        : FSM encodings (IDLE, CONV, DONE)
//   - BCD_UMBRAL     : digit value at or above which the add-3 fix is applied
//   - BCD_SUMA       : correction added to a digit before each shift
//   - BCD_DIG_CLAMP  : digit value used when the result is clamped to 99
//   - CNT_W          : width of the iteration counter (covers DATA_W up to 15)
// -----------------------------------------------------------------------------
package binario_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_UMBRAL    = 4'd5;
  localparam logic [3:0] BCD_SUMA      = 4'd3;
  localparam logic [3:0] BCD_DIG_CLAMP = 4'd9;
  localparam int         CNT_W         = 4;

endpackage

// File: rtl/binario_bcd_ajuste.sv
// -----------------------------------------------------------------------------
// bcd_ajuste_digito
// Double-dabble correction for one BCD scratch digit: a digit of 5 or more
// gets 3 added so that the following left shift carries correctly into the
// next decimal digit.
// Ports:
//   i_digito : scratch digit before correction
//   o_digito : corrected digit (combinational)
// -----------------------------------------------------------------------------
module bcd_ajuste_digito
  import binario_bcd_pkg::*;
(
  input  logic [3:0] i_digito,
  output logic [3:0] o_digito
);

  assign o_digito = (i_digito >= BCD_UMBRAL) ? (i_digito + BCD_SUMA) : i_digito;

endmodule

// File: rtl/binario_bcd.sv
// -----------------------------------------------------------------------------
// binario_bcd
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// FSM IDLE -> CONV (DATA_W iterations) -> DONE -> IDLE.
// Optional build macro: BCD_CLAMP_99_EN -- results above 99 are presented as
// 0/9/9 with oOverflow=1. Without it the full three-digit result is output
// and oOverflow is constant 0.
// Parameters:
//   DATA_W      : binary input width (4..9)
// Ports:
//   iClk        : clock, rising edge
//   iReset      : asynchronous active-high reset
//   iStart      : conversion request, only looked at in IDLE
//   ivBinario   : unsigned value, captured when iStart is accepted
//   oBusy       : high in CONV or DONE (decoded from state)
//   oDone       : registered one-cycle pulse when new digits are presented
//   ovUnidades  : BCD units of the last result
//   ovDecenas   : BCD tens of the last result
//   ovCentenas  : BCD hundreds of the last result
//   oOverflow   : last result exceeded 99 and was clamped
// -----------------------------------------------------------------------------
module binario_bcd
  import binario_bcd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [DATA_W-1:0] ivBinario,
  output logic              oBusy,
  output logic              oDone,
  output logic [3:0]        ovUnidades,
  output logic [3:0]        ovDecenas,
  output logic [3:0]        ovCentenas,
  output logic              oOverflow
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_sr;
  logic [3:0]        r_uni;
  logic [3:0]        r_dec;
  logic [3:0]        r_cen;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        w_adj_uni;
  logic [3:0]        w_adj_dec;
  logic [3:0]        w_adj_cen;
  logic [3:0]        r_out_uni;
  logic [3:0]        r_out_dec;
  logic [3:0]        r_out_cen;
  logic              r_done;
`ifdef BCD_CLAMP_99_EN
  logic              r_ovf;
`endif

  // State register
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (iStart) w_next = ST_CONV;
      ST_CONV: if (r_cnt == CNT_LAST) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign oBusy = (r_state == ST_CONV) || (r_state == ST_DONE);

  bcd_ajuste_digito u_aj_uni (.i_digito(r_uni), .o_digito(w_adj_uni));
  bcd_ajuste_digito u_aj_dec (.i_digito(r_dec), .o_digito(w_adj_dec));
  bcd_ajuste_digito u_aj_cen (.i_digito(r_cen), .o_digito(w_adj_cen));

  // Datapath: capture, shift/adjust iterations, output load
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_sr      <= '0;
      r_uni     <= '0;
      r_dec     <= '0;
      r_cen     <= '0;
      r_cnt     <= '0;
      r_out_uni <= '0;
      r_out_dec <= '0;
      r_out_cen <= '0;
      r_done    <= 1'b0;
`ifdef BCD_CLAMP_99_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_sr  <= ivBinario;
            r_uni <= '0;
            r_dec <= '0;
            r_cen <= '0;
            r_cnt <= '0;
          end
        end
        ST_CONV: begin
          // The hundreds digit never reaches 8 for DATA_W <= 9, so the bit
          // shifted out of the top is always zero.
          {r_cen, r_dec, r_uni, r_sr} <= {w_adj_cen, w_adj_dec, w_adj_uni, r_sr} << 1;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_DONE: begin
          r_done <= 1'b1;
`ifdef BCD_CLAMP_99_EN
          if (r_cen != 4'd0) begin
            r_out_cen <= 4'd0;
            r_out_dec <= BCD_DIG_CLAMP;
            r_out_uni <= BCD_DIG_CLAMP;
            r_ovf     <= 1'b1;
          end else begin
            r_out_cen <= r_cen;
            r_out_dec <= r_dec;
            r_out_uni <= r_uni;
            r_ovf     <= 1'b0;
          end
`else
          r_out_cen <= r_cen;
          r_out_dec <= r_dec;
          r_out_uni <= r_uni;
`endif
        end
        default: ;
      endcase
    end
  end

  assign oDone      = r_done;
  assign ovUnidades = r_out_uni;
  assign ovDecenas  = r_out_dec;
  assign ovCentenas = r_out_cen;
`ifdef BCD_CLAMP_99_EN
  assign oOverflow  = r_ovf;
`else
  assign oOverflow  = 1'b0;
`endif

endmodule

// File: tb/tb_binario_bcd.sv
// -----------------------------------------------------------------------------
// tb_binario_bcd
// Self-checking bench for binario_bcd (DATA_W = 8). Expected results are
// queued when a conversion is started and compared when oDone is seen.
// Honours BCD_CLAMP_99_EN for the expected values.
// -----------------------------------------------------------------------------
module tb_binario_bcd;

  localparam int DATA_W = 8;

  logic              iClk = 1'b0;
  logic              iReset;
  logic              iStart;
  logic [DATA_W-1:0] ivBinario;
  logic              oBusy;
  logic              oDone;
  logic [3:0]        ovUnidades;
  logic [3:0]        ovDecenas;
  logic [3:0]        ovCentenas;
  logic              oOverflow;

  binario_bcd #(.DATA_W(DATA_W)) dut (
    .iClk       (iClk),
    .iReset     (iReset),
    .iStart     (iStart),
    .ivBinario  (ivBinario),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .ovUnidades (ovUnidades),
    .ovDecenas  (ovDecenas),
    .ovCentenas (ovCentenas),
    .oOverflow  (oOverflow)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
    logic       ovf;
    int         start;
  } exp_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [3:0]        c;
    logic [3:0]        d;
    logic [3:0]        u;
    logic              ovf;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input int v, input int start);
    exp_t r;
    r.c     = 4'(v / 100);
    r.d     = 4'((v / 10) % 10);
    r.u     = 4'(v % 10);
    r.ovf   = 1'b0;
`ifdef BCD_CLAMP_99_EN
    if (v > 99) begin
      r.c   = 4'd0;
      r.d   = 4'd9;
      r.u   = 4'd9;
      r.ovf = 1'b1;
    end
`endif
    r.start = start;
    return r;
  endfunction

  // Scoreboard: compare each oDone pulse against the oldest queued result
  always @(negedge iClk) begin : mon
    exp_t e;
    if (!iReset && oDone === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got oDone=1, expected no pulse (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("digits", {20'd0, ovCentenas, ovDecenas, ovUnidades}, {20'd0, e.c, e.d, e.u});
        check("overflow", {31'd0, oOverflow}, {31'd0, e.ovf});
        check("latency", cyc - e.start, DATA_W + 1);
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(posedge iClk);
      k++;
    end
    check("done_count", n_done, target);
  endtask

  task automatic run_conv(input vec_t v);
    exp_t e;
    int   d0;
    d0 = n_done;
    @(negedge iClk);
    iStart    = 1'b1;
    ivBinario = v.val;
    e.c = v.c; e.d = v.d; e.u = v.u; e.ovf = v.ovf; e.start = cyc + 1;
    sb.push_back(e);
    @(negedge iClk);
    iStart    = 1'b0;
    ivBinario = DATA_W'($urandom);
    check("busy_in_conv", {31'd0, oBusy}, 32'd1);
    wait_done(d0 + 1, 20);
  endtask

  initial begin : main
    exp_t e;
    vec_t v;
    int   d0;
    int   s;

    tbl[0] = {8'd0,   4'd0, 4'd0, 4'd0, 1'b0};
    tbl[1] = {8'd9,   4'd0, 4'd0, 4'd9, 1'b0};
    tbl[2] = {8'd10,  4'd0, 4'd1, 4'd0, 1'b0};
    tbl[3] = {8'd99,  4'd0, 4'd9, 4'd9, 1'b0};
    tbl[4] = {8'd37,  4'd0, 4'd3, 4'd7, 1'b0};
    tbl[5] = {8'd59,  4'd0, 4'd5, 4'd9, 1'b0};
`ifdef BCD_CLAMP_99_EN
    tbl[6] = {8'd100, 4'd0, 4'd9, 4'd9, 1'b1};
    tbl[7] = {8'd255, 4'd0, 4'd9, 4'd9, 1'b1};
    tbl[8] = {8'd128, 4'd0, 4'd9, 4'd9, 1'b1};
    tbl[9] = {8'd199, 4'd0, 4'd9, 4'd9, 1'b1};
`else
    tbl[6] = {8'd100, 4'd1, 4'd0, 4'd0, 1'b0};
    tbl[7] = {8'd255, 4'd2, 4'd5, 4'd5, 1'b0};
    tbl[8] = {8'd128, 4'd1, 4'd2, 4'd8, 1'b0};
    tbl[9] = {8'd199, 4'd1, 4'd9, 4'd9, 1'b0};
`endif

    iReset    = 1'b1;
    iStart    = 1'b0;
    ivBinario = '0;
    #12;
    check("reset_digits", {20'd0, ovCentenas, ovDecenas, ovUnidades}, 32'd0);
    check("reset_done",   {31'd0, oDone}, 32'd0);
    check("reset_busy",   {31'd0, oBusy}, 32'd0);
    check("reset_ovf",    {31'd0, oOverflow}, 32'd0);
    @(negedge iClk);
    iReset = 1'b0;
    @(negedge iClk);

    // Table of single conversions
    for (int i = 0; i < 10; i++) begin
      run_conv(tbl[i]);
      @(negedge iClk);
      check("idle_after_done", {31'd0, oBusy}, 32'd0);
    end

    // A few random values against the decimal model
    for (int i = 0; i < 4; i++) begin
      e     = model($urandom_range(255), 0);
      v.val = DATA_W'($urandom_range(255));
      e     = model(int'(v.val), 0);
      v.c = e.c; v.d = e.d; v.u = e.u; v.ovf = e.ovf;
      run_conv(v);
    end

    // Results must hold while idle
    repeat (5) @(negedge iClk);
    e = model(int'(v.val), 0);
    check("hold_digits", {20'd0, ovCentenas, ovDecenas, ovUnidades}, {20'd0, e.c, e.d, e.u});

    // Start with 37, then a second request on cycle 3 of CONV must be ignored
    d0 = n_done;
    @(negedge iClk);
    iStart = 1'b1;
    ivBinario = 8'd37;
    sb.push_back(model(37, cyc + 1));
    @(negedge iClk);
    iStart = 1'b0;
    repeat (2) @(negedge iClk);
    iStart = 1'b1;
    ivBinario = 8'd200;
    @(negedge iClk);
    iStart = 1'b0;
    wait_done(d0 + 1, 20);
    repeat (12) @(posedge iClk);
    check("single_done", n_done, d0 + 1);

    // Reset on cycle 4 of CONV aborts; first edge after release starts 58
    @(negedge iClk);
    iStart = 1'b1;
    ivBinario = 8'd77;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (3) @(negedge iClk);
    d0 = n_done;
    #2 iReset = 1'b1;
    #1;
    check("abort_digits", {20'd0, ovCentenas, ovDecenas, ovUnidades}, 32'd0);
    check("abort_busy",   {31'd0, oBusy}, 32'd0);
    check("abort_done",   {31'd0, oDone}, 32'd0);
    repeat (2) @(negedge iClk);
    iReset = 1'b0;
    iStart = 1'b1;
    ivBinario = 8'd58;
    sb.push_back(model(58, cyc + 1));
    @(negedge iClk);
    iStart = 1'b0;
    wait_done(d0 + 1, 20);

    // iStart held for 30 cycles: a conversion every 10 cycles
    d0 = n_done;
    @(negedge iClk);
    iStart = 1'b1;
    ivBinario = 8'd123;
    s = cyc + 1;
    sb.push_back(model(123, s));
    sb.push_back(model(123, s + 10));
    sb.push_back(model(123, s + 20));
    repeat (30) @(negedge iClk);
    iStart = 1'b0;
    wait_done(d0 + 3, 40);
    repeat (12) @(posedge iClk);
    check("held_done_count", n_done, d0 + 3);
    check("held_idle_busy", {31'd0, oBusy}, 32'd0);
    check("queue_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

endmodule
